// File: rtl/vmx_mm_wrapper.sv
// Memory-mapped 4x4 signed 16-bit matrix multiply engine.
// Reads A (words 0x00-0x03) and B (words 0x04-0x07), writes C = A*B with
// 32-bit wrapping elements to words 0x08-0x0F, two words per write cycle.
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous active-high reset
//   ctrl   - control, bit 1 = start, other bits ignored
//   d_i    - 64-bit read data, combinational from addr
//   addr   - word address (registered)
//   wr_en  - write strobe; d_o[127:64] -> addr, d_o[63:0] -> addr+1 (registered)
//   d_o    - one C row {c0,c1,c2,c3}, combinational from A/B registers
//   flag   - state code, zero-extended (registered)
module vmx_mm_wrapper (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  ctrl,
  input  logic [63:0]  d_i,
  output logic [7:0]   addr,
  output logic         wr_en,
  output logic [127:0] d_o,
  output logic [31:0]  flag
);

  localparam int unsigned ROWS  = 4;
  localparam int unsigned EW    = 16;
  localparam int unsigned WW    = 64;
  localparam int unsigned CW    = 32;
  localparam int unsigned AW    = 8;
  localparam int unsigned FW    = 32;
  localparam int unsigned CNT_W = 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_WRITE  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    addr_d;
  logic             wr_en_d;
  logic             load_a, load_b;
  logic [WW-1:0]    a_q [ROWS];
  logic [WW-1:0]    b_q [ROWS];
  logic             start;
  logic             unused_ctrl;

  assign start       = ctrl[1];
  assign unused_ctrl = ^{ctrl[31:2], ctrl[0]};

  // Next-state, row counter and next registered-output decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = '0;
    wr_en_d = 1'b0;
    load_a  = 1'b0;
    load_b  = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LOAD_A;
          cnt_d   = '0;
        end
      end
      S_LOAD_A: begin
        load_a = 1'b1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ROWS - 1)) state_d = S_LOAD_B;
      end
      S_LOAD_B: begin
        load_b = 1'b1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ROWS - 1)) state_d = S_WRITE;
      end
      S_WRITE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ROWS - 1)) state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered, so decode them from the upcoming state/count
    unique case (state_d)
      S_LOAD_A: addr_d = AW'(cnt_d);
      S_LOAD_B: addr_d = AW'(ROWS) + AW'(cnt_d);
      S_WRITE: begin
        addr_d  = AW'(8) + AW'({cnt_d, 1'b0});
        wr_en_d = 1'b1;
      end
      default: addr_d = '0;
    endcase
  end

  // State, counter, output and matrix registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr    <= '0;
      wr_en   <= 1'b0;
      flag    <= '0;
      for (int r = 0; r < int'(ROWS); r++) begin
        a_q[r] <= '0;
        b_q[r] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr    <= addr_d;
      wr_en   <= wr_en_d;
      flag    <= FW'(state_d);
      if (load_a) a_q[cnt_q] <= d_i;
      if (load_b) b_q[cnt_q] <= d_i;
    end
  end

  // Row cnt_q of C, valid in the same cycle as wr_en; sums wrap modulo 2^32
  logic signed [EW-1:0] ea, eb;
  logic signed [CW-1:0] prod, acc;

  always_comb begin
    d_o  = '0;
    ea   = '0;
    eb   = '0;
    prod = '0;
    acc  = '0;
    if (state_q == S_WRITE) begin
      for (int j = 0; j < int'(ROWS); j++) begin
        acc = '0;
        for (int k = 0; k < int'(ROWS); k++) begin
          ea   = a_q[cnt_q][(int'(ROWS) - 1 - k) * int'(EW) +: EW];
          eb   = b_q[k][(int'(ROWS) - 1 - j) * int'(EW) +: EW];
          prod = ea * eb;
          acc  = acc + prod;
        end
        d_o[(int'(ROWS) - 1 - j) * int'(CW) +: CW] = acc;
      end
    end
  end

endmodule

// File: tb/tb_vmx_mm_wrapper.sv
// Self-checking bench for vmx_mm_wrapper: fixed vector table, randomized
// matrices against a plain-arithmetic matrix model, and hand sequences for
// timing, reset, busy-start and rerun behaviour.
module tb_vmx_mm_wrapper;

  logic         clk;
  logic         rst;
  logic [31:0]  ctrl;
  logic [63:0]  d_i;
  logic [7:0]   addr;
  logic         wr_en;
  logic [127:0] d_o;
  logic [31:0]  flag;

  logic [63:0] mem [16];
  int n_cmp = 0;
  int n_err = 0;
  int wr_cnt = 0;

  vmx_mm_wrapper dut (
    .clk   (clk),
    .rst   (rst),
    .ctrl  (ctrl),
    .d_i   (d_i),
    .addr  (addr),
    .wr_en (wr_en),
    .d_o   (d_o),
    .flag  (flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational-read memory model
  assign d_i = (addr < 8'd16) ? mem[addr[3:0]] : 64'h0;

  typedef struct {
    string           name;
    logic [3:0][63:0] a;
    logic [3:0][63:0] b;
    logic [7:0][63:0] c;
  } vec_t;

  vec_t vecs [3];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clock: memory write happens at the edge ending a wr_en cycle
  task automatic tick();
    logic [3:0] wa;
    @(negedge clk);
    if (wr_en) begin
      wa = addr[3:0];
      mem[wa]       = d_o[127:64];
      mem[wa + 4'd1] = d_o[63:0];
      wr_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    ctrl = 32'h2;
    tick();
    ctrl = 32'h0;
  endtask

  task automatic load_mats(input logic [3:0][63:0] a, input logic [3:0][63:0] b);
    for (int r = 0; r < 4; r++) begin
      mem[r]     = a[r];
      mem[r + 4] = b[r];
    end
    for (int r = 8; r < 16; r++) mem[r] = 64'hDEAD_BEEF_DEAD_BEEF;
  endtask

  task automatic wait_done(input string nm);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 40; t++) begin
      if (flag == 32'd4) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk({nm, "_done_reached"}, 128'(ok), 128'd1);
  endtask

  task automatic wait_flag(input logic [31:0] f, input string nm);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 40; t++) begin
      if (flag == f) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk({nm, "_flag_reached"}, 128'(ok), 128'd1);
  endtask

  task automatic check_results(input string nm, input logic [7:0][63:0] c);
    for (int n = 0; n < 8; n++)
      chk($sformatf("%s_mem%0h", nm, n + 8), 128'(mem[n + 8]), 128'(c[n]));
  endtask

  task automatic run_and_check(input string nm, input logic [7:0][63:0] c);
    int w0;
    w0 = wr_cnt;
    pulse_start();
    wait_done(nm);
    check_results(nm, c);
    chk({nm, "_write_count"}, 128'(wr_cnt - w0), 128'd4);
    chk({nm, "_flag_done"}, 128'(flag), 128'd4);
  endtask

  // Reference: C = A*B from signed 16-bit elements, truncated to 32 bits
  task automatic model(input logic [3:0][63:0] a, input logic [3:0][63:0] b,
                       output logic [7:0][63:0] c);
    logic [3:0][31:0] row;
    longint s;
    shortint x, y;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        s = 0;
        for (int k = 0; k < 4; k++) begin
          x = shortint'(a[i] >> (48 - 16 * k));
          y = shortint'(b[k] >> (48 - 16 * j));
          s = s + longint'(x) * longint'(y);
        end
        row[3 - j] = s[31:0];
      end
      c[2 * i]     = {row[3], row[2]};
      c[2 * i + 1] = {row[1], row[0]};
    end
  endtask

  initial begin
    logic [3:0][63:0] ra, rb;
    logic [7:0][63:0] rc;
    int w0;

    rst  = 1'b1;
    ctrl = 32'h0;
    for (int r = 0; r < 16; r++) mem[r] = 64'h0;

    // Diagonal product
    vecs[0].name = "diag";
    vecs[0].a = {64'h0000_0000_0000_FFFF, 64'h0000_0000_FFFF_0000,
                 64'h0000_0001_0000_0000, 64'h0001_0000_0000_0000};
    vecs[0].b = {64'h0000_0000_0000_FFFF, 64'h0000_0000_0001_0000,
                 64'h0000_FFFF_0000_0000, 64'h0001_0000_0000_0000};
    vecs[0].c = {64'h00000000_00000001, 64'h0,
                 64'hFFFFFFFF_00000000, 64'h0,
                 64'h0, 64'h00000000_FFFFFFFF,
                 64'h0, 64'h00000001_00000000};
    // Overflow wrap: every element -32768
    vecs[1].name = "wrap";
    vecs[1].a = {4{64'h8000_8000_8000_8000}};
    vecs[1].b = {4{64'h8000_8000_8000_8000}};
    vecs[1].c = '0;
    // General: rows {1,2,3,4}, B = 2*I
    vecs[2].name = "general";
    vecs[2].a = {4{64'h0001_0002_0003_0004}};
    vecs[2].b = {64'h0000_0000_0000_0002, 64'h0000_0000_0002_0000,
                 64'h0000_0002_0000_0000, 64'h0002_0000_0000_0000};
    vecs[2].c = {4{64'h00000006_00000008, 64'h00000002_00000004}};

    tick();
    tick();
    rst = 1'b0;
    chk("reset_flag", 128'(flag), 128'd0);
    chk("reset_addr", 128'(addr), 128'd0);
    chk("reset_wr_en", 128'(wr_en), 128'd0);
    chk("reset_d_o", d_o, 128'd0);

    // Reserved ctrl bits alone must not start
    ctrl = 32'hFFFF_FFFD;
    tick();
    tick();
    ctrl = 32'h0;
    chk("reserved_no_start", 128'(flag), 128'd0);

    // Table-driven vectors
    for (int v = 0; v < 3; v++) begin
      load_mats(vecs[v].a, vecs[v].b);
      run_and_check(vecs[v].name, vecs[v].c);
    end

    // Cycle-exact address / strobe / flag sequence
    load_mats(vecs[2].a, vecs[2].b);
    pulse_start();
    for (int n = 1; n <= 13; n++) begin
      int ph, ix;
      logic [7:0] ea;
      ph = (n - 1) / 4;
      ix = (n - 1) % 4;
      if (n == 13) begin
        chk("seq_flag_13", 128'(flag), 128'd4);
        chk("seq_addr_13", 128'(addr), 128'd0);
        chk("seq_wr_13", 128'(wr_en), 128'd0);
        chk("seq_d_o_13", d_o, 128'd0);
      end else begin
        ea = (ph == 0) ? 8'(ix) : (ph == 1) ? 8'(4 + ix) : 8'(8 + 2 * ix);
        chk($sformatf("seq_flag_%0d", n), 128'(flag), 128'(ph + 1));
        chk($sformatf("seq_addr_%0d", n), 128'(addr), 128'(ea));
        chk($sformatf("seq_wr_%0d", n), 128'(wr_en), 128'(ph == 2));
        tick();
      end
    end
    check_results("seq", vecs[2].c);

    // Randomized matrices against the model
    for (int r = 0; r < 6; r++) begin
      for (int q = 0; q < 4; q++) begin
        ra[q] = {$urandom, $urandom};
        rb[q] = {$urandom, $urandom};
      end
      model(ra, rb, rc);
      load_mats(ra, rb);
      run_and_check($sformatf("rand%0d", r), rc);
    end

    // Start during WRITE is ignored; start in DONE reruns identically
    load_mats(vecs[0].a, vecs[0].b);
    w0 = wr_cnt;
    pulse_start();
    wait_flag(32'd3, "busy");
    pulse_start();
    wait_done("busy");
    chk("busy_write_count", 128'(wr_cnt - w0), 128'd4);
    check_results("busy", vecs[0].c);
    tick();
    tick();
    chk("busy_stays_done", 128'(flag), 128'd4);
    for (int r = 8; r < 16; r++) mem[r] = 64'h0123_4567_89AB_CDEF;
    run_and_check("rerun", vecs[0].c);

    // Reset mid-LOAD_B
    load_mats(vecs[2].a, vecs[2].b);
    pulse_start();
    wait_flag(32'd2, "rst_mid");
    rst = 1'b1;
    tick();
    chk("rst_mid_flag", 128'(flag), 128'd0);
    chk("rst_mid_addr", 128'(addr), 128'd0);
    chk("rst_mid_wr_en", 128'(wr_en), 128'd0);
    chk("rst_mid_d_o", d_o, 128'd0);
    tick();
    rst = 1'b0;
    w0 = wr_cnt;
    begin
      bit quiet;
      quiet = 1'b1;
      for (int t = 0; t < 20; t++) begin
        tick();
        if (flag != 32'd0 || addr != 8'd0 || wr_en) quiet = 1'b0;
      end
      chk("rst_mid_quiet", 128'(quiet), 128'd1);
    end
    chk("rst_mid_no_writes", 128'(wr_cnt - w0), 128'd0);

    // A fresh run after reset still works
    run_and_check("post_rst", vecs[2].c);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vmx_mm_wrapper.md
# vmx_mm_wrapper

Memory-mapped 4×4 signed 16-bit matrix-multiply engine for the vector/matrix accelerator. On a start command it reads matrix A (words 0x00–0x03) and matrix B (words 0x04–0x07) from an external 64-bit word memory. It computes C = A×B with 32-bit elements and writes C back to words 0x08–0x0F, two words per write cycle. Status is reported on `flag` for the host/PS side.

## Interface
- No parameters.
- `clk`    in   1    single clock, all logic on rising edge.
- `rst`    in   1    reset, synchronous and active-high.
- `ctrl`   in   32   control. Bit 1 is start; all other bits are reserved and ignored.
- `d_i`    in   64   read data. The external memory drives it combinationally from `addr`.
- `addr`   out  8    word address, used for both reads and writes.
- `wr_en`  out  1    write strobe. When high, memory stores `d_o[127:64]` at `addr` and `d_o[63:0]` at `addr+1` on the clock edge.
- `d_o`    out  128  write data: one C row as {c0,c1,c2,c3}, 32 bits each, c0 in the MSBs.
- `flag`   out  32   state code, zero-extended. 0 IDLE, 1 LOAD_A, 2 LOAD_B, 3 WRITE, 4 DONE.

## Operation
- **Word format.**
  - A 64-bit matrix word holds one row as {e0[63:48], e1[47:32], e2[31:16], e3[15:0]}.
  - Elements are two's-complement 16-bit.
- **IDLE** (flag=0):
  - Outputs are addr=0, wr_en=0, d_o=0.
  - `ctrl[1]` sampled high at a rising edge moves the FSM to LOAD_A with row counter k=0.
- **LOAD_A** (flag=1):
  - addr=k for k=0..3.
  - At each rising edge the block captures d_i into A row k and increments k.
  - After row 3 is captured, the FSM goes to LOAD_B with k=0.
- **LOAD_B** (flag=2):
  - addr=4+k for k=0..3.
  - At each rising edge the block captures d_i into B row k.
  - After row 3 is captured, the FSM goes to WRITE with i=0.
- **WRITE** (flag=3):
  - wr_en=1 and addr=0x08+2i for i=0..3.
  - d_o = row i of C, where c_j = Σ_k A[i][k]·B[k][j].
  - Arithmetic: signed 16×16→32 products, summed modulo 2^32 (wraparound, no saturation).
  - The row is computed combinationally from the registered A/B, so d_o is valid in the same cycle as wr_en.
  - After i=3, the FSM goes to DONE.
- **DONE** (flag=4):
  - Outputs are addr=0, wr_en=0, d_o=0.
  - DONE is held until the next start. Start in DONE behaves as in IDLE and starts a fresh run that re-reads A and B.
- **Start while busy:** start during LOAD_A, LOAD_B or WRITE is ignored.
- **Reset:**
  - Reset has priority over everything, including a mid-run operation.
  - It forces IDLE, k=i=0, clears the A/B registers, and sets all outputs to 0 on the next edge.
- `addr`, `flag` and `wr_en` are registered (driven from the state/counter registers). `d_o` is combinational from the registers.

## Timing
- Start sampled at edge T0. LOAD_A then occupies cycles T0+1..T0+4, LOAD_B T0+5..T0+8, and WRITE T0+9..T0+12.
- DONE is entered at T0+13.
- Total: 12 busy cycles.
- Read latency is zero: d_i must be valid before the edge that ends the cycle in which addr is presented.
- Exactly 4 write cycles per run, with addresses 0x08, 0x0A, 0x0C, 0x0E in order.
- A start pulse needs to be high at only one rising edge. A level held high restarts from DONE on the first edge after DONE is entered.

## Test plan
- **Reset:** assert rst for 2 cycles mid-LOAD_B.
  - Required: flag=0, addr=0, wr_en=0, d_o=0 next cycle.
  - Without a new start, no further memory reads or writes occur.
- **Diagonal product:** A=diag(1,1,−1,−1), B=diag(1,−1,1,−1), one start.
  - mem[8]=0x00000001_00000000, mem[9]=0.
  - mem[A]=0x00000000_FFFFFFFF, mem[B]=0.
  - mem[C]=0, mem[D]=0xFFFFFFFF_00000000.
  - mem[E]=0, mem[F]=0x00000000_00000001.
  - flag=4 afterward.
- **Sequence check:** the address sequence must be 0,1,2,3,4,5,6,7, then 8,A,C,E with wr_en=1 only on the last four. flag steps 1×4, 2×4, 3×4, then 4.
- **Overflow wrap:** all A and B elements 0x8000.
  - Each c = 4·2^30 = 2^32, which wraps to 0x00000000.
  - All eight result words are 0.
- **Start while busy:** a second start pulse during WRITE is ignored (the run ends with exactly 4 writes). A start pulse in DONE reruns and reproduces identical results.
- **General values:** A rows {1,2,3,4}×4 and B = identity·2.
  - Row 0 is written as mem[8]=0x00000002_00000004 and mem[9]=0x00000006_00000008.
  - Rows 1–3 have the same contents at 0x0A–0x0F.
